// File: rtl/pint_bridge_v2_if.sv
// Host-side handshake bundle for pint_bridge_v2: TX character stream in, RX character stream out.
`timescale 1ns/1ps
interface pint_bridge_v2_if #(parameter int CHAR_W = 8);
  logic              tx_valid;
  logic              tx_ready;
  logic [CHAR_W-1:0] tx_char;
  logic              tx_last;
  logic              tx_cmd_type;
  logic              rx_valid;
  logic              rx_ready;
  logic [CHAR_W-1:0] rx_char;
  logic              rx_last;

  modport master (
    output tx_valid, tx_char, tx_last, tx_cmd_type, rx_ready,
    input  tx_ready, rx_valid, rx_char, rx_last
  );
  modport slave (
    input  tx_valid, tx_char, tx_last, tx_cmd_type, rx_ready,
    output tx_ready, rx_valid, rx_char, rx_last
  );
endinterface

// File: rtl/pint_bridge_v2.sv
// PINT host bridge: buffers TX/RX frames in FIFOs and serialises them over the PINT pins
// with a programmable bit clock; RX frames are rebuilt from the serial stream.
`timescale 1ns/1ps
module pint_bridge_v2 #(
  parameter int CHAR_W = 8,
  parameter int TX_AW  = 4,
  parameter int RX_AW  = 4,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_cfg,
  pint_bridge_v2_if.slave  host,
  output logic             rx_overflow,
  input  logic             ovf_clr,
  output logic             busy,
  output logic             PINT_CLK,
  output logic             PINT_RESETN,
  output logic             PINT_WRREQ,
  output logic             PINT_WRDATA,
  output logic             PINT_RDREQ,
  input  logic             PINT_RDRDY,
  input  logic             PINT_RDDATA
);
  localparam int CW = $clog2(CHAR_W);
  localparam logic [CW-1:0] BIT_LAST = CW'(CHAR_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RX, ST_END} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, baud_q, baud_d;
  logic              pclk_q, pclk_d, wrreq_q, wrreq_d, wrdata_q, wrdata_d, rdreq_q, rdreq_d;
  logic [CHAR_W-1:0] tx_sr_q, tx_sr_d, hold_q, hold_d;
  logic [CHAR_W-2:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              in_cmd_q, in_cmd_d, cur_last_q, cur_last_d, hold_vld_q, hold_vld_d;
  logic              ovf_q, ovf_d, rdrdy_meta_q, rdrdy_s_q;
  logic [TX_AW:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_frames_q, tx_frames_d;
  logic [RX_AW:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

  // TX entries carry {cmd, last, char}; cmd is only looked at on a frame's first char
  logic [CHAR_W+1:0] tx_mem_q [1 << TX_AW];
  logic [CHAR_W:0]   rx_mem_q [1 << RX_AW];

  logic              tx_full, tx_push, tx_pop, rx_full, rx_empty, rx_pop, rx_push, rx_do_push, tick;
  logic [CHAR_W+1:0] tx_head;
  logic [CHAR_W:0]   rx_push_dat;

  assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                    (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
  assign rx_full  = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) &&
                    (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign tx_push  = host.tx_valid && !tx_full;
  assign rx_pop   = !rx_empty && host.rx_ready;
  assign tx_head  = tx_mem_q[tx_rp_q[TX_AW-1:0]];
  assign tick     = (state_q == ST_TX || state_q == ST_RX) && (baud_q == div_q);

  assign host.tx_ready = !tx_full;
  assign host.rx_valid = !rx_empty;
  assign {host.rx_last, host.rx_char} = rx_mem_q[rx_rp_q[RX_AW-1:0]];
  assign rx_overflow = ovf_q;
  assign busy        = (state_q != ST_IDLE);
  assign PINT_CLK    = pclk_q;
  assign PINT_RESETN = ~reset;
  assign PINT_WRREQ  = wrreq_q;
  assign PINT_WRDATA = wrdata_q;
  assign PINT_RDREQ  = rdreq_q;

  always_comb begin
    state_d = state_q;   div_d = div_q;         baud_d = baud_q;
    pclk_d = pclk_q;     wrreq_d = wrreq_q;     wrdata_d = wrdata_q;  rdreq_d = rdreq_q;
    tx_sr_d = tx_sr_q;   bit_cnt_d = bit_cnt_q; in_cmd_d = in_cmd_q;  cur_last_d = cur_last_q;
    rx_sr_d = rx_sr_q;   rx_cnt_d = rx_cnt_q;   hold_d = hold_q;      hold_vld_d = hold_vld_q;
    tx_pop = 1'b0;       rx_push = 1'b0;        rx_push_dat = '0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        pclk_d = 1'b0;
        if (rdrdy_s_q) begin
          state_d = ST_RX;  rdreq_d = 1'b1;  div_d = div_cfg;
          rx_cnt_d = '0;    hold_vld_d = 1'b0;
        end else if (tx_frames_q != '0) begin
          state_d = ST_TX;  div_d = div_cfg;  wrdata_d = tx_head[CHAR_W+1];
          in_cmd_d = 1'b1;  bit_cnt_d = '0;   cur_last_d = 1'b0;
        end
      end
      ST_TX, ST_RX: begin
        baud_d = tick ? '0 : baud_q + DIV_W'(1);
        if (tick) pclk_d = !pclk_q;
        if (state_q == ST_TX && tick) begin
          if (!pclk_q) begin
            wrreq_d = 1'b1;
          end else if (in_cmd_q || bit_cnt_q == BIT_LAST) begin
            if (!in_cmd_q && cur_last_q) begin
              state_d = ST_END;
            end else begin
              // first bit of the next char goes out now, so it leaves the FIFO now
              tx_pop = 1'b1;  in_cmd_d = 1'b0;  bit_cnt_d = '0;
              cur_last_d = tx_head[CHAR_W];
              wrdata_d   = tx_head[CHAR_W-1];
              tx_sr_d    = {tx_head[CHAR_W-2:0], 1'b0};
            end
          end else begin
            wrdata_d  = tx_sr_q[CHAR_W-1];
            tx_sr_d   = {tx_sr_q[CHAR_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        if (state_q == ST_RX && tick) begin
          if (!pclk_q) begin
            if (rx_cnt_q == BIT_LAST) begin
              // last is unknown until RDRDY drops, so a char waits in hold for its successor
              rx_cnt_d = '0;  hold_d = {rx_sr_q, PINT_RDDATA};  hold_vld_d = 1'b1;
              if (hold_vld_q) begin
                rx_push = 1'b1;  rx_push_dat = {1'b0, hold_q};
              end
            end else begin
              rx_sr_d  = {rx_sr_q[CHAR_W-3:0], PINT_RDDATA};
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end else if (!rdrdy_s_q) begin
            state_d = ST_END;  hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              rx_push = 1'b1;  rx_push_dat = {1'b1, hold_q};
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;  wrreq_d = 1'b0;  rdreq_d = 1'b0;
        pclk_d = 1'b0;      wrdata_d = 1'b0; baud_d = '0;
      end
    endcase
  end

  always_comb begin
    rx_do_push  = rx_push && !rx_full;
    ovf_d       = (rx_push && rx_full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    tx_wp_d     = tx_push    ? tx_wp_q + (TX_AW+1)'(1) : tx_wp_q;
    tx_rp_d     = tx_pop     ? tx_rp_q + (TX_AW+1)'(1) : tx_rp_q;
    rx_wp_d     = rx_do_push ? rx_wp_q + (RX_AW+1)'(1) : rx_wp_q;
    rx_rp_d     = rx_pop     ? rx_rp_q + (RX_AW+1)'(1) : rx_rp_q;
    tx_frames_d = tx_frames_q;
    case ({tx_push && host.tx_last, tx_pop && tx_head[CHAR_W]})
      2'b10:   tx_frames_d = tx_frames_q + (TX_AW+1)'(1);
      2'b01:   tx_frames_d = tx_frames_q - (TX_AW+1)'(1);
      default: tx_frames_d = tx_frames_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push)    tx_mem_q[tx_wp_q[TX_AW-1:0]] <= {host.tx_cmd_type, host.tx_last, host.tx_char};
    if (rx_do_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;  div_q <= '0;      baud_q <= '0;
      pclk_q <= 1'b0;      wrreq_q <= 1'b0;  wrdata_q <= 1'b0;  rdreq_q <= 1'b0;
      tx_sr_q <= '0;       bit_cnt_q <= '0;  in_cmd_q <= 1'b0;  cur_last_q <= 1'b0;
      rx_sr_q <= '0;       rx_cnt_q <= '0;   hold_q <= '0;      hold_vld_q <= 1'b0;
      ovf_q <= 1'b0;       rdrdy_meta_q <= 1'b0;  rdrdy_s_q <= 1'b0;
      tx_wp_q <= '0;       tx_rp_q <= '0;    tx_frames_q <= '0;
      rx_wp_q <= '0;       rx_rp_q <= '0;
    end else begin
      state_q <= state_d;  div_q <= div_d;      baud_q <= baud_d;
      pclk_q <= pclk_d;    wrreq_q <= wrreq_d;  wrdata_q <= wrdata_d;  rdreq_q <= rdreq_d;
      tx_sr_q <= tx_sr_d;  bit_cnt_q <= bit_cnt_d;  in_cmd_q <= in_cmd_d;  cur_last_q <= cur_last_d;
      rx_sr_q <= rx_sr_d;  rx_cnt_q <= rx_cnt_d;    hold_q <= hold_d;      hold_vld_q <= hold_vld_d;
      ovf_q <= ovf_d;      rdrdy_meta_q <= PINT_RDRDY;  rdrdy_s_q <= rdrdy_meta_q;
      tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_frames_q <= tx_frames_d;
      rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;
    end
  end
endmodule

// File: tb/tb_pint_bridge_v2.sv
// Directed bench for pint_bridge_v2: TX serialisation, RX framing, overflow, arbitration, reset abort.
`timescale 1ns/1ps
module tb_pint_bridge_v2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] div_cfg = '0;
  logic        ovf_clr = 1'b0;
  logic        rx_overflow, busy;
  logic        PINT_CLK, PINT_RESETN, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ;
  logic        PINT_RDRDY = 1'b0;
  logic        PINT_RDDATA = 1'b0;

  int checks = 0;
  int errors = 0;

  pint_bridge_v2_if #(.CHAR_W(8)) host ();

  pint_bridge_v2 #(.CHAR_W(8), .TX_AW(4), .RX_AW(4), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .div_cfg(div_cfg), .host(host),
    .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .busy(busy),
    .PINT_CLK(PINT_CLK), .PINT_RESETN(PINT_RESETN), .PINT_WRREQ(PINT_WRREQ),
    .PINT_WRDATA(PINT_WRDATA), .PINT_RDREQ(PINT_RDREQ),
    .PINT_RDRDY(PINT_RDRDY), .PINT_RDDATA(PINT_RDDATA)
  );

  always #5 clk = ~clk;

  // Wire-level monitor: bits seen at each rising PINT_CLK inside a WRREQ window
  logic tx_bits[$];
  int   wrreq_windows = 0;
  int   pclk_high_cnt = 0;
  logic pclk_prev = 1'b0;
  logic wrreq_prev = 1'b0;
  logic rx_send[$];

  always @(negedge clk) begin
    if (PINT_CLK && !pclk_prev && PINT_WRREQ) tx_bits.push_back(PINT_WRDATA);
    if (PINT_WRREQ && !wrreq_prev) wrreq_windows++;
    if (PINT_CLK) pclk_high_cnt++;
    pclk_prev  = PINT_CLK;
    wrreq_prev = PINT_WRREQ;
  end

  function automatic logic [31:0] bits_value();
    logic [31:0] v = '0;
    foreach (tx_bits[i]) v = {v[30:0], tx_bits[i]};
    return v;
  endfunction

  task automatic clear_mon();
    tx_bits.delete();
    wrreq_windows = 0;
    pclk_high_cnt = 0;
  endtask

  task automatic push_char(input logic [7:0] c, input logic last, input logic cmd);
    host.tx_valid = 1'b1;  host.tx_char = c;  host.tx_last = last;  host.tx_cmd_type = cmd;
    @(negedge clk);
    host.tx_valid = 1'b0;  host.tx_last = 1'b0;
  endtask

  task automatic wait_busy(input logic want, input int budget, input string what);
    int n = 0;
    while (busy !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required %b", what, busy, n, want);
    end
  endtask

  task automatic wait_pclk(input logic lvl, input string what);
    int n = 0;
    while (!(PINT_CLK === lvl && PINT_RDREQ === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s: PINT_CLK=%b RDREQ=%b, required PINT_CLK=%b RDREQ=1", what, PINT_CLK, PINT_RDREQ, lvl);
    end
  endtask

  task automatic load_rx(input logic [7:0] c);
    for (int b = 7; b >= 0; b--) rx_send.push_back(c[b]);
  endtask

  // Feeds rx_send one bit per rising PINT_CLK, then drops RDRDY and waits for the frame to close
  task automatic rx_frame();
    PINT_RDRDY = 1'b1;
    foreach (rx_send[i]) begin
      wait_pclk(1'b0, "rx_wait_low");
      PINT_RDDATA = rx_send[i];
      wait_pclk(1'b1, "rx_wait_high");
    end
    PINT_RDRDY = 1'b0;
    rx_send.delete();
    wait_busy(1'b0, 100, "rx_end");
  endtask

  task automatic pop_check(input logic [7:0] c, input logic last, input string what);
    checks++;
    if (host.rx_valid !== 1'b1 || host.rx_char !== c || host.rx_last !== last) begin
      errors++;
      $display("FAIL %s: valid=%b char=%h last=%b, required valid=1 char=%h last=%b",
               what, host.rx_valid, host.rx_char, host.rx_last, c, last);
    end
    host.rx_ready = 1'b1;
    @(negedge clk);
    host.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (PINT_RESETN !== 1'b0) begin errors++; $display("FAIL reset_resetn_low: %b required 0", PINT_RESETN); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({host.tx_ready, host.rx_valid, rx_overflow, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status: txr/rxv/ovf/busy=%b required 1000", {host.tx_ready, host.rx_valid, rx_overflow, busy});
    end
    checks++;
    if ({PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ, PINT_RESETN} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_pins: clk/wrreq/wrdata/rdreq/resetn=%b required 00001",
               {PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ, PINT_RESETN});
    end
  endtask

  task automatic test_tx_single();
    div_cfg = 16'd0;
    clear_mon();
    push_char(8'hA5, 1'b1, 1'b1);
    wait_busy(1'b1, 20, "tx1_start");
    wait_busy(1'b0, 100, "tx1_end");
    checks++;
    if (tx_bits.size() !== 9 || bits_value() !== 32'h1A5) begin
      errors++;
      $display("FAIL tx1_bits: %0d bits value %h, required 9 bits value 1a5", tx_bits.size(), bits_value());
    end
    checks++;
    if (wrreq_windows !== 1 || PINT_WRREQ !== 1'b0) begin
      errors++;
      $display("FAIL tx1_wrreq: windows=%0d wrreq=%b, required 1 and 0", wrreq_windows, PINT_WRREQ);
    end
  endtask

  task automatic test_tx_multi();
    div_cfg = 16'd2;
    clear_mon();
    push_char(8'h12, 1'b0, 1'b0);
    push_char(8'h34, 1'b0, 1'b1);
    push_char(8'h56, 1'b1, 1'b1);
    wait_busy(1'b1, 20, "tx3_start");
    div_cfg = 16'd0;
    wait_busy(1'b0, 400, "tx3_end");
    checks++;
    if (tx_bits.size() !== 25 || bits_value() !== 32'h0012_3456 || wrreq_windows !== 1) begin
      errors++;
      $display("FAIL tx3_bits: %0d bits value %h windows %0d, required 25 bits value 00123456 windows 1",
               tx_bits.size(), bits_value(), wrreq_windows);
    end
    checks++;
    if (pclk_high_cnt !== 75) begin
      errors++;
      $display("FAIL tx3_divider: PINT_CLK high %0d cycles, required 75", pclk_high_cnt);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || host.tx_ready !== 1'b1 || wrreq_windows !== 1) begin
      errors++;
      $display("FAIL tx3_drained: busy=%b tx_ready=%b windows=%0d, required 0 1 1", busy, host.tx_ready, wrreq_windows);
    end
  endtask

  task automatic test_rx_two();
    div_cfg = 16'd1;
    load_rx(8'h3C);
    load_rx(8'hC3);
    rx_frame();
    pop_check(8'h3C, 1'b0, "rx2_first");
    pop_check(8'hC3, 1'b1, "rx2_second");
    checks++;
    if (host.rx_valid !== 1'b0) begin errors++; $display("FAIL rx2_empty: rx_valid=%b required 0", host.rx_valid); end
  endtask

  task automatic test_rx_overflow();
    div_cfg = 16'd0;
    for (int i = 0; i < 17; i++) load_rx(8'(8'h80 + i));
    rx_frame();
    checks++;
    if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: rx_overflow=%b required 1", rx_overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: rx_overflow=%b required 0", rx_overflow); end
    for (int i = 0; i < 16; i++) pop_check(8'(8'h80 + i), 1'b0, $sformatf("ovf_entry%0d", i));
    checks++;
    if (host.rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: rx_valid=%b required 0", host.rx_valid); end
  endtask

  task automatic test_rx_priority();
    div_cfg = 16'd0;
    clear_mon();
    PINT_RDRDY = 1'b1;
    @(negedge clk);
    push_char(8'h7E, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (PINT_RDREQ !== 1'b1 || PINT_WRREQ !== 1'b0) begin
      errors++;
      $display("FAIL prio_rx_first: rdreq=%b wrreq=%b, required 1 0", PINT_RDREQ, PINT_WRREQ);
    end
    load_rx(8'h5A);
    rx_frame();
    wait_busy(1'b1, 20, "prio_tx_start");
    wait_busy(1'b0, 100, "prio_tx_end");
    checks++;
    if (tx_bits.size() !== 9 || bits_value() !== 32'h17E) begin
      errors++;
      $display("FAIL prio_tx_bits: %0d bits value %h, required 9 bits value 17e", tx_bits.size(), bits_value());
    end
    checks++;
    if (host.rx_valid !== 1'b1 || host.rx_char !== 8'h5A || host.rx_last !== 1'b1) begin
      errors++;
      $display("FAIL prio_rx_char: valid=%b char=%h last=%b, required 1 5a 1", host.rx_valid, host.rx_char, host.rx_last);
    end
  endtask

  // RX FIFO still holds 0x5A here, so the abort also has to empty it
  task automatic test_reset_mid_tx();
    int n = 0;
    div_cfg = 16'd1;
    clear_mon();
    push_char(8'hF0, 1'b0, 1'b1);
    push_char(8'h0F, 1'b1, 1'b1);
    while (tx_bits.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_bits.size() !== 4) begin errors++; $display("FAIL abort_reach_bit4: %0d bits, required 4", tx_bits.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ, busy, host.tx_ready, host.rx_valid, rx_overflow} !== 8'b0000_0100) begin
      errors++;
      $display("FAIL abort_outputs: clk/wrreq/wrdata/rdreq/busy/txr/rxv/ovf=%b required 00000100",
               {PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ, busy, host.tx_ready, host.rx_valid, rx_overflow});
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_bits.size() !== 4 || host.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_fifos_empty: busy=%b bits=%0d rx_valid=%b, required 0 4 0", busy, tx_bits.size(), host.rx_valid);
    end
  endtask

  initial begin
    host.tx_valid = 1'b0;  host.tx_char = '0;  host.tx_last = 1'b0;
    host.tx_cmd_type = 1'b0;  host.rx_ready = 1'b0;
    test_reset();
    test_tx_single();
    test_tx_multi();
    test_rx_two();
    test_rx_overflow();
    test_rx_priority();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
